wb_master_req: RTL

- Single-transfer Wishbone B4 classic master: converts a local command/response handshake into one bus cycle per command.
- Sits directly upstream of Wishbone slaves (e.g. the NOP slave, memory or peripheral slaves) and drives their cyc/stb/we/adr/dat/sel.
- Terminates each cycle on ack_i, err_i or a local timeout, then returns read data and status to the requester.

---
 rtl/wb_master_req.sv | 113 +++++++++++
 1 files changed

// File: rtl/wb_master_req.sv
// Wishbone B4 classic single-transfer master: one bus cycle per local command.
// Latency: accept at edge N, stb from N+1, response from N+2 with a zero-wait slave; response is held until rsp_ready_i.
module wb_master_req #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16,
  localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic [1:0]            rsp_status_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic [SEL_WIDTH-1:0]  sel_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i,
  input  logic                  err_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  // Counter only needs to reach TIMEOUT-1; with TIMEOUT=0 it free-runs unused.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          timeout_hit;

  assign cmd_ready_o = (state == S_IDLE) && !rst_i;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cyc_o        <= 1'b0;
      stb_o        <= 1'b0;
      we_o         <= 1'b0;
      adr_o        <= '0;
      dat_o        <= '0;
      sel_o        <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= '0;
      rsp_status_o <= ST_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            we_o  <= cmd_we_i;
            adr_o <= cmd_adr_i;
            dat_o <= cmd_dat_i;
            sel_o <= cmd_sel_i;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            cnt   <= '0;
            state <= S_BUS;
          end
        end
        S_BUS: begin
          cnt <= cnt + 1'b1;
          if (err_i || ack_i || timeout_hit) begin
            // adr_o/dat_o deliberately keep their values after the cycle ends.
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            sel_o       <= '0;
            rsp_valid_o <= 1'b1;
            state       <= S_RESP;
            if (err_i) begin
              rsp_status_o <= ST_ERR;
              rsp_dat_o    <= '0;
            end else if (ack_i) begin
              rsp_status_o <= ST_OK;
              rsp_dat_o    <= we_o ? '0 : dat_i;
            end else begin
              rsp_status_o <= ST_TIMEOUT;
              rsp_dat_o    <= '0;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
